udp_tx_arbiter: RTL and testbench



---
 rtl/udp_stream_pkg.sv | 18 +
 rtl/udp_tx_arbiter_rr_pick.sv | 37 +++
 rtl/udp_tx_arbiter.sv | 175 +++++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_stream_pkg.sv
// Shared definitions for the UDP stream TX path: arbiter FSM states,
// the stream data width and an index-width helper.
package udp_stream_pkg;

    localparam int UDP_TDATA_WIDTH = 64;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_e;

    // Width of an index into n items; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/udp_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority selector.
// Ports:
//   req        in  N   request vector
//   last_grant in  IW  index granted most recently
//   any        out 1   at least one request present
//   next_idx   out IW  first requester after last_grant, wrapping
module rr_pick
    import udp_stream_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic          any,
    output logic [IW-1:0] next_idx
);

    logic [IW-1:0] k;

    // Walk offsets from N down to 1 and let later hits overwrite
    // earlier ones: the smallest offset (nearest after last_grant)
    // ends up as the winner without needing an early exit.
    always_comb begin
        any      = 1'b0;
        next_idx = last_grant;
        k        = '0;
        for (int i = N; i >= 1; i--) begin
            k = IW'((int'(last_grant) + i) % N);
            if (req[k]) begin
                any      = 1'b1;
                next_idx = k;
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: packet-level round-robin arbiter sharing one AXI4-Stream
// TX port between NUM_SRC UDP frame generators, with optional pacing gap.
// Ports:
//   m00_axis_aclk / m00_axis_areset  clock, synchronous active-high reset
//   s_axis_tvalid/tdata/tlast/tready per-source input streams
//   m00_axis_tvalid/tdata/tlast/tready  stream towards the MAC
//   src_enable   per-source arbitration mask (sampled in IDLE only)
//   gap_cycles   idle cycles after each frame (sampled on the tlast beat)
//   grant_idx    current or most recent grantee
//   busy         high while a frame is being forwarded
//   src_pkt_count  per-source 32-bit frame counters (UDP_TX_ARB_STATS_EN)
// Build option: define UDP_TX_ARB_STATS_EN to add the frame counters.
module udp_tx_arbiter
    import udp_stream_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int TDATA_WIDTH = UDP_TDATA_WIDTH,
    parameter int GAP_WIDTH   = 16
) (
    input  logic                           m00_axis_aclk,
    input  logic                           m00_axis_areset,
    input  logic [NUM_SRC-1:0]             s_axis_tvalid,
    input  logic [NUM_SRC*TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]             s_axis_tlast,
    output logic [NUM_SRC-1:0]             s_axis_tready,
    output logic                           m00_axis_tvalid,
    output logic [TDATA_WIDTH-1:0]         m00_axis_tdata,
    output logic                           m00_axis_tlast,
    input  logic                           m00_axis_tready,
    input  logic [NUM_SRC-1:0]             src_enable,
    input  logic [GAP_WIDTH-1:0]           gap_cycles,
    output logic [idx_width(NUM_SRC)-1:0]  grant_idx,
    output logic                           busy
`ifdef UDP_TX_ARB_STATS_EN
    ,
    output logic [NUM_SRC*32-1:0]          src_pkt_count
`endif
);

    localparam int IW = idx_width(NUM_SRC);

    arb_state_e           state_q, state_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic [IW-1:0]        last_q,  last_d;
    logic [GAP_WIDTH-1:0] gap_q,   gap_d;
    logic                 busy_q,  busy_d;

    logic [NUM_SRC-1:0]     cand;
    logic                   pick_any;
    logic [IW-1:0]          pick_idx;
    logic                   sel_valid;
    logic                   sel_last;
    logic [TDATA_WIDTH-1:0] sel_data;
    logic                   last_beat;

    assign cand = s_axis_tvalid & src_enable;

    rr_pick #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_pick (
        .req        (cand),
        .last_grant (last_q),
        .any        (pick_any),
        .next_idx   (pick_idx)
    );

    // Pure mux from the granted source; nothing is buffered.
    always_comb begin
        sel_valid     = 1'b0;
        sel_last      = 1'b0;
        sel_data      = '0;
        s_axis_tready = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (grant_q == IW'(k)) begin
                sel_valid = s_axis_tvalid[k];
                sel_last  = s_axis_tlast[k];
                sel_data  = s_axis_tdata[k*TDATA_WIDTH +: TDATA_WIDTH];
                s_axis_tready[k] = busy_q & m00_axis_tready;
            end
        end
    end

    assign m00_axis_tvalid = busy_q & sel_valid;
    assign m00_axis_tlast  = busy_q & sel_last;
    assign m00_axis_tdata  = busy_q ? sel_data : '0;
    assign last_beat       = m00_axis_tvalid & m00_axis_tready
                           & m00_axis_tlast;

    assign grant_idx = grant_q;
    assign busy      = busy_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        gap_d   = gap_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // Grant is held until the tlast beat, even if the
                // source stalls or is disabled in the meantime.
                if (last_beat) begin
                    if (gap_cycles != '0) begin
                        gap_d   = gap_cycles;
                        state_d = ARB_GAP;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            ARB_GAP: begin
                gap_d = gap_q - GAP_WIDTH'(1);
                if (gap_q <= GAP_WIDTH'(1)) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        busy_d = (state_d == ARB_BUSY);
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_SRC - 1);
            gap_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            busy_q  <= busy_d;
        end
    end

`ifdef UDP_TX_ARB_STATS_EN
    logic [31:0] cnt_q [NUM_SRC];
    logic [31:0] cnt_d [NUM_SRC];

    // Counters wrap naturally at 2^32.
    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            cnt_d[k] = cnt_q[k];
            if (last_beat && (grant_q == IW'(k))) begin
                cnt_d[k] = cnt_q[k] + 32'd1;
            end
            src_pkt_count[k*32 +: 32] = cnt_q[k];
        end
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end
`endif

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Self-checking bench for udp_tx_arbiter: grant table, directed frame
// sequences and randomized traffic against a frame-level reference model.
module tb_udp_tx_arbiter;
    import udp_stream_pkg::*;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int GW = 16;
    localparam int IW = idx_width(N);

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   s_tvalid;
    logic [N*W-1:0] s_tdata;
    logic [N-1:0]   s_tlast;
    logic [N-1:0]   s_tready;
    logic           m_tvalid;
    logic [W-1:0]   m_tdata;
    logic           m_tlast;
    logic           m_tready;
    logic [N-1:0]   src_en;
    logic [GW-1:0]  gap;
    logic [IW-1:0]  gidx;
    logic           busy;
`ifdef UDP_TX_ARB_STATS_EN
    logic [N*32-1:0] pkt_cnt;
`endif

    udp_tx_arbiter #(
        .NUM_SRC     (N),
        .TDATA_WIDTH (W),
        .GAP_WIDTH   (GW)
    ) dut (
        .m00_axis_aclk   (clk),
        .m00_axis_areset (rst),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tdata    (s_tdata),
        .s_axis_tlast    (s_tlast),
        .s_axis_tready   (s_tready),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tready (m_tready),
        .src_enable      (src_en),
        .gap_cycles      (gap),
        .grant_idx       (gidx),
        .busy            (busy)
`ifdef UDP_TX_ARB_STATS_EN
        ,
        .src_pkt_count   (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Source generators: frames with tdata = {src, frame, beat}.
    int len[N];
    int fix_len[N];
    int beat[N];
    int frames_left[N];
    int frame_no[N];
    int vprob[N];
    int rdy_mode;

    // Frame-level reference: who owns the link, gap left, counts.
    int          m_owner;
    int          m_gapleft;
    int          m_last;
    int          m_grant;
    int unsigned m_cnt[N];

    logic         e_valid;
    logic         e_last;
    logic         e_busy;
    logic [W-1:0] e_data;
    logic [N-1:0] e_ready;

    typedef struct {
        int cyc;
        int src;
        int beat;
        bit last;
    } beat_t;
    beat_t obs[$];

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] en;
        int           exp;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int new_len(input int k);
        return (fix_len[k] > 0) ? fix_len[k] : int'($urandom_range(5, 1));
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_gapleft = 0;
        m_last    = N - 1;
        m_grant   = 0;
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
    endtask

    task automatic src_set(input int k, input int frames, input int l,
                           input int vp);
        frames_left[k] = frames;
        fix_len[k]     = l;
        len[k]         = new_len(k);
        beat[k]        = 0;
        vprob[k]       = vp;
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            s_tvalid[k] = (frames_left[k] > 0)
                        && (int'($urandom_range(99)) < vprob[k]);
            s_tlast[k]  = (beat[k] == len[k] - 1);
            s_tdata[k*W +: W] = {16'(k), 16'(frame_no[k]), 32'(beat[k])};
        end
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(1));
        endcase
    endtask

    task automatic expect_out();
        e_valid = 1'b0;
        e_last  = 1'b0;
        e_busy  = 1'b0;
        e_data  = '0;
        e_ready = '0;
        if (m_owner >= 0) begin
            e_busy           = 1'b1;
            e_valid          = s_tvalid[m_owner];
            e_last           = s_tlast[m_owner];
            e_data           = s_tdata[m_owner*W +: W];
            e_ready[m_owner] = m_tready;
        end
    endtask

    task automatic advance();
        bit found;
        int k;
        found = 1'b0;
        if (m_owner >= 0) begin
            if (s_tvalid[m_owner] && m_tready && s_tlast[m_owner]) begin
                m_cnt[m_owner]++;
                m_gapleft = int'(gap);
                m_owner   = -1;
            end
        end else if (m_gapleft > 0) begin
            m_gapleft--;
        end else begin
            for (int i = 1; i <= N; i++) begin
                k = (m_last + i) % N;
                if (!found && s_tvalid[k] && src_en[k]) begin
                    found   = 1'b1;
                    m_owner = k;
                    m_last  = k;
                    m_grant = k;
                end
            end
        end
        for (int j = 0; j < N; j++) begin
            if (e_ready[j] && s_tvalid[j]) begin
                if (s_tlast[j]) begin
                    frames_left[j]--;
                    frame_no[j]++;
                    beat[j] = 0;
                    len[j]  = new_len(j);
                end else begin
                    beat[j]++;
                end
            end
        end
    endtask

    task automatic step();
        drive();
        expect_out();
        @(negedge clk);
        chk("busy", 64'(busy), 64'(e_busy));
        chk("grant_idx", 64'(gidx), 64'(m_grant));
        chk("m_tvalid", 64'(m_tvalid), 64'(e_valid));
        chk("s_tready", 64'(s_tready), 64'(e_ready));
        chk("m_tlast", 64'(m_tlast), 64'(e_last));
        chk("m_tdata", m_tdata, e_data);
        if (m_tvalid && m_tready) begin
            obs.push_back('{cyc, int'(m_tdata[63:48]),
                            int'(m_tdata[31:0]), m_tlast});
        end
        @(posedge clk);
        advance();
        cyc++;
        #1;
    endtask

    function automatic bit all_done();
        bit d;
        d = (m_owner < 0) && (m_gapleft == 0);
        for (int k = 0; k < N; k++) if (frames_left[k] > 0) d = 1'b0;
        return d;
    endfunction

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_done(input string name, input int limit);
        int n;
        n = 0;
        while (!all_done() && n < limit) begin
            step();
            n++;
        end
        checks++;
        if (!all_done()) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles", name, limit);
        end
    endtask

    task automatic stats_chk();
`ifdef UDP_TX_ARB_STATS_EN
        for (int k = 0; k < N; k++) begin
            chk("pkt_count", 64'(pkt_cnt[k*32 +: 32]), 64'(m_cnt[k]));
        end
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        model_reset();
        for (int k = 0; k < N; k++) begin
            beat[k] = 0;
            len[k]  = new_len(k);
        end
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(gidx), 64'd0);
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tready", 64'(s_tready), 64'd0);
        chk("rst_tdata", m_tdata, 64'd0);
        stats_chk();
    endtask

    initial begin
        int prev;
        int c2;
        int co;

        // Grant decisions from a fresh reset (last_grant = 3).
        tbl[0]  = '{4'b1111, 4'b1111, 0};
        tbl[1]  = '{4'b1111, 4'b1111, 1};
        tbl[2]  = '{4'b0101, 4'b1111, 2};
        tbl[3]  = '{4'b0101, 4'b1111, 0};
        tbl[4]  = '{4'b1111, 4'b1011, 1};
        tbl[5]  = '{4'b1111, 4'b1011, 3};
        tbl[6]  = '{4'b1111, 4'b1011, 0};
        tbl[7]  = '{4'b0100, 4'b1011, -1};
        tbl[8]  = '{4'b0000, 4'b1111, -1};
        tbl[9]  = '{4'b1000, 4'b1111, 3};
        tbl[10] = '{4'b1001, 4'b1111, 0};
        tbl[11] = '{4'b0010, 4'b0010, 1};

        rst      = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b1;
        src_en   = '1;
        gap      = '0;
        rdy_mode = 0;
        for (int k = 0; k < N; k++) begin
            frame_no[k] = 0;
            src_set(k, 0, 1, 100);
        end
        repeat (2) @(posedge clk);
        do_reset();

        // Table of single-beat frames.
        prev = 0;
        for (int i = 0; i < 12; i++) begin
            s_tvalid = tbl[i].v;
            s_tlast  = '1;
            src_en   = tbl[i].en;
            m_tready = 1'b1;
            for (int k = 0; k < N; k++) s_tdata[k*W +: W] = {16'(k), 48'd0};
            @(negedge clk);
            chk("tbl_a_busy", 64'(busy), 64'd0);
            chk("tbl_a_tvalid", 64'(m_tvalid), 64'd0);
            @(posedge clk); #1;
            @(negedge clk);
            if (tbl[i].exp >= 0) begin
                chk("tbl_grant", 64'(gidx), 64'(tbl[i].exp));
                chk("tbl_b_busy", 64'(busy), 64'd1);
                chk("tbl_b_tvalid", 64'(m_tvalid), 64'd1);
                chk("tbl_b_tready", 64'(s_tready), 64'(1 << tbl[i].exp));
                chk("tbl_b_src", 64'(m_tdata[63:48]), 64'(tbl[i].exp));
                prev = tbl[i].exp;
            end else begin
                chk("tbl_hold_grant", 64'(gidx), 64'(prev));
                chk("tbl_b_idle", 64'(busy), 64'd0);
            end
            @(posedge clk); #1;
            s_tvalid = '0;
            @(negedge clk);
            chk("tbl_c_idle", 64'(busy), 64'd0);
            @(posedge clk); #1;
        end
        src_en = '1;

        // First-frame order: sources 0 and 2, 6 beats, no gap.
        do_reset();
        obs.delete();
        src_set(0, 1, 6, 100);
        src_set(2, 1, 6, 100);
        run_done("first_frame", 100);
        chk("ff_beats", 64'(obs.size()), 64'd12);
        if (obs.size() == 12) begin
            for (int j = 0; j < 12; j++) begin
                chk("ff_src", 64'(obs[j].src), (j < 6) ? 64'd0 : 64'd2);
                chk("ff_beat", 64'(obs[j].beat), 64'(j % 6));
            end
            chk("ff_bubble", 64'(obs[6].cyc - obs[5].cyc), 64'd2);
        end

        // Round-robin fairness: 12 frames of 3 beats.
        do_reset();
        obs.delete();
        for (int k = 0; k < N; k++) src_set(k, 3, 3, 100);
        run_done("fairness", 200);
        chk("rr_beats", 64'(obs.size()), 64'd36);
        if (obs.size() == 36) begin
            for (int f = 0; f < 12; f++) begin
                for (int j = 0; j < 3; j++) begin
                    chk("rr_src", 64'(obs[f*3+j].src), 64'(f % 4));
                    chk("rr_beat", 64'(obs[f*3+j].beat), 64'(j));
                end
            end
        end

        // Back-pressure: MAC ready toggles during a source 1 frame.
        do_reset();
        obs.delete();
        rdy_mode = 1;
        src_set(1, 1, 6, 100);
        run_done("backpressure", 100);
        rdy_mode = 0;
        chk("bp_beats", 64'(obs.size()), 64'd6);
        if (obs.size() == 6) begin
            for (int j = 0; j < 6; j++) begin
                chk("bp_src", 64'(obs[j].src), 64'd1);
                chk("bp_beat", 64'(obs[j].beat), 64'(j));
                chk("bp_last", 64'(obs[j].last), 64'(j == 5));
            end
        end

        // Gap of 5 between back-to-back frames from source 3.
        obs.delete();
        gap = 16'd5;
        src_set(3, 2, 4, 100);
        run_done("gap", 100);
        gap = '0;
        chk("gap_beats", 64'(obs.size()), 64'd8);
        if (obs.size() == 8) begin
            chk("gap_spacing", 64'(obs[4].cyc - obs[3].cyc), 64'd7);
        end

        // Enable mask: source 2 masked off while valid.
        obs.delete();
        src_en = 4'b1011;
        for (int k = 0; k < N; k++) src_set(k, 2, 2, 100);
        run_n(40);
        c2 = 0;
        co = 0;
        foreach (obs[j]) begin
            if (obs[j].src == 2) c2++;
            else co++;
        end
        chk("mask_src2", 64'(c2), 64'd0);
        chk("mask_others", 64'(co), 64'd12);
        frames_left[2] = 0;
        src_en = '1;
        run_done("mask_drain", 50);

        // Disabling the owner mid-frame does not cut the frame.
        do_reset();
        obs.delete();
        src_set(0, 1, 6, 100);
        run_n(3);
        src_en = 4'b1110;
        run_done("mask_midframe", 50);
        src_en = '1;
        chk("midmask_beats", 64'(obs.size()), 64'd6);
        foreach (obs[j]) chk("midmask_src", 64'(obs[j].src), 64'd0);

        // Stats, then reset in the middle of a frame.
        do_reset();
        src_set(1, 3, 2, 100);
        run_done("stats", 50);
        stats_chk();
`ifdef UDP_TX_ARB_STATS_EN
        chk("stats_src1", 64'(pkt_cnt[63:32]), 64'd3);
`endif
        src_set(0, 1, 6, 100);
        run_n(3);
        do_reset();
        run_done("post_reset", 50);
        stats_chk();

        // Randomized traffic against the reference model.
        do_reset();
        rdy_mode = 2;
        for (int k = 0; k < N; k++) begin
            src_set(k, 25, 0, int'($urandom_range(100, 60)));
        end
        for (int c = 0; c < 1500; c++) begin
            if (c % 25 == 0) src_en = 4'($urandom_range(15));
            gap = GW'($urandom_range(3));
            if (c == 700) do_reset();
            step();
        end
        src_en = '1;
        run_done("rand_drain", 4000);
        stats_chk();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
